mdu_multicycle: RTL

//  Parametrised multi-cycle multiply/divide unit with HI/LO registers for the pipelined MIPS core.

---
 rtl/mdu_multicycle_pkg.sv | 40 ++++
 rtl/mdu_calc.sv | 79 +++++++
 rtl/mdu_multicycle.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mdu_multicycle_pkg.sv
// -----------------------------------------------------------------------------
// mdu_multicycle_pkg
//   Shared definitions for the multi-cycle multiply/divide unit: operation
//   encodings, FSM state type, and small helpers shared by the MDU datapath
//   and the decoder's stall logic.
// -----------------------------------------------------------------------------
package mdu_multicycle_pkg;

    // Operation encodings as driven on the MDU op port by decode.
    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5,
        MDU_NOP6  = 3'd6,
        MDU_NOP7  = 3'd7
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    function automatic logic is_mult(input mdu_op_e op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

    function automatic logic is_div(input mdu_op_e op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    // Decoder stall rule: an instruction that reads HI/LO or issues another
    // mult/div must hold in decode while an MDU op is launching or in flight.
    function automatic logic mdu_stall(input logic start, input logic busy);
        return start | busy;
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// -----------------------------------------------------------------------------
// mdu_calc
//   Combinational arithmetic for the MDU. Operates on the latched operands and
//   produces the values written into HI/LO when the op completes.
// Ports
//   op          in   latched operation
//   a, b        in   latched rs / rt operands
//   hi_next     out  value for HI (product upper half / remainder)
//   lo_next     out  value for LO (product lower half / quotient)
//   div_by_zero out  divide op with b==0; HI/LO must not be written
// -----------------------------------------------------------------------------
module mdu_calc
    import mdu_multicycle_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  mdu_op_e          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next,
    output logic             div_by_zero
);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic signed [2*WIDTH-1:0] prod_s;
    logic        [2*WIDTH-1:0] prod_u;
    logic                      div_ovf;
    logic        [WIDTH-1:0]   b_sdiv;
    logic        [WIDTH-1:0]   b_udiv;
    logic signed [WIDTH-1:0]   quo_s;
    logic signed [WIDTH-1:0]   rem_s;
    logic        [WIDTH-1:0]   quo_u;
    logic        [WIDTH-1:0]   rem_u;

    // Sign/zero-extend to full width so the product is the exact 2*WIDTH result.
    assign prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    // Divisor substitution keeps the dividers free of undefined cases.
    // For MOST_NEG / -1, dividing by 1 yields exactly the wrapped result
    // required (quotient = a, remainder = 0). A zero divisor is replaced too;
    // its result is discarded via div_by_zero.
    assign div_ovf = (a == MOST_NEG) && (b == ALL_ONES);
    assign b_sdiv  = (div_ovf || (b == '0)) ? ONE : b;
    assign b_udiv  = (b == '0) ? ONE : b;

    // SystemVerilog signed division truncates toward zero and the remainder
    // takes the dividend's sign, matching MIPS DIV semantics.
    assign quo_s = $signed(a) / $signed(b_sdiv);
    assign rem_s = $signed(a) % $signed(b_sdiv);
    assign quo_u = a / b_udiv;
    assign rem_u = a % b_udiv;

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        hi_next = '0;
        lo_next = '0;
        unique case (op)
            MDU_MULT:  {hi_next, lo_next} = prod_s;
            MDU_MULTU: {hi_next, lo_next} = prod_u;
            MDU_DIV: begin
                lo_next = quo_s;
                hi_next = rem_s;
            end
            MDU_DIVU: begin
                lo_next = quo_u;
                hi_next = rem_u;
            end
            default: ;
        endcase
    end

    assign div_by_zero = is_div(op) && (b == '0);

endmodule

// File: rtl/mdu_multicycle.sv
// -----------------------------------------------------------------------------
// mdu_multicycle
//   Multi-cycle multiply/divide unit with HI/LO registers, sitting beside the
//   EX-stage ALU. MULT/MULTU take MULT_LAT cycles, DIV/DIVU take DIV_LAT
//   cycles; MTHI/MTLO write in a single cycle without raising busy.
// Ports
//   clk     in   rising-edge clock
//   reset   in   asynchronous active-high reset
//   start   in   one-cycle launch pulse (accepted only when idle)
//   op      in   operation code (see mdu_op_e)
//   src_a   in   rs operand
//   src_b   in   rt operand
//   cancel  in   abort the in-flight op; HI/LO keep their values
//   busy    out  registered, high while an op is in flight
//   hi, lo  out  HI / LO registers
// -----------------------------------------------------------------------------
module mdu_multicycle
    import mdu_multicycle_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    mdu_op_e          op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;

    mdu_op_e          op_in;
    logic [WIDTH-1:0] hi_next;
    logic [WIDTH-1:0] lo_next;
    logic             div_by_zero;

    assign op_in = mdu_op_e'(op);

    mdu_calc #(.WIDTH(WIDTH)) u_calc (
        .op          (op_q),
        .a           (a_q),
        .b           (b_q),
        .hi_next     (hi_next),
        .lo_next     (lo_next),
        .div_by_zero (div_by_zero)
    );

    // Next-state / datapath control. A new op is accepted only in IDLE, so a
    // start coinciding with completion (still RUN) is ignored.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_mult(op_in) || is_div(op_in)) begin
                        op_d    = op_in;
                        a_d     = src_a;
                        b_d     = src_b;
                        cnt_d   = is_mult(op_in) ? CNT_W'(MULT_LAT) : CNT_W'(DIV_LAT);
                        busy_d  = 1'b1;
                        state_d = ST_RUN;
                    end else if (op_in == MDU_MTHI) begin
                        hi_d = src_a;
                    end else if (op_in == MDU_MTLO) begin
                        lo_d = src_a;
                    end
                end
            end

            ST_RUN: begin
                // Cancel wins over a completion in the same cycle.
                if (cancel) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_ONE) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                    if (!div_by_zero) begin
                        hi_d = hi_next;
                        lo_d = lo_next;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            op_q    <= MDU_MULT;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
